// File: rtl/watch_pkg.sv
// Shared definitions for the watch controller: mode encoding, field limits
// and a small wrap-around increment helper.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_t;

  localparam logic [5:0] HOURS_MAX   = 6'd23;
  localparam logic [5:0] MINUTES_MAX = 6'd59;
  localparam logic [5:0] SECONDS_MAX = 6'd59;

  // Increment a time field, returning to zero once it has reached its limit.
  function automatic logic [5:0] inc_wrap(input logic [5:0] value, input logic [5:0] max);
    return (value == max) ? 6'd0 : value + 6'd1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 and flags the terminal count.
// While clear is high the count is held at zero and no tick is produced.
module tick_gen #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] count_reg;

  // Free-running modulo-CLK_HZ counter, forced to zero by reset or clear.
  always_ff @(posedge clk_in) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == LAST) && !clear;

endmodule

// File: rtl/watch_ctrl.sv
// 24-hour watch controller: runs hh:mm:ss from a prescaled tick and lets
// the user set hours then minutes with a mode and an increment button.
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int CLK_HZ = 100000000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       sec_pulse,
  output logic       blink
);

  localparam int BW = $clog2(CLK_HZ);
  localparam logic [BW-1:0] BLINK_LAST = BW'(CLK_HZ / 4 - 1);

  mode_t         state_reg;
  mode_t         state_next;
  logic          mode_prev_reg;
  logic          inc_prev_reg;
  logic          mode_edge;
  logic          inc_edge;
  logic          inc_hr;
  logic          inc_min;
  logic          clear_sec;
  logic          tick;
  logic          presc_clear;
  logic [4:0]    hours_reg;
  logic [5:0]    minutes_reg;
  logic [5:0]    seconds_reg;
  logic          pulse_reg;
  logic [BW-1:0] blink_cnt_reg;
  logic          blink_reg;

  assign mode_edge   = btn_mode && !mode_prev_reg;
  assign inc_edge    = btn_inc && !inc_prev_reg;
  // The prescaler only runs in RUN, so leaving SET_MIN restarts it from zero.
  assign presc_clear = (state_reg != MODE_RUN);

  tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick_gen (
    .clk_in(clk_in),
    .rst   (rst),
    .clear (presc_clear),
    .tick  (tick)
  );

  // Previous button samples; preset to 1 so a button held through reset is not an edge.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      mode_prev_reg <= 1'b1;
      inc_prev_reg  <= 1'b1;
    end else begin
      mode_prev_reg <= btn_mode;
      inc_prev_reg  <= btn_inc;
    end
  end

  // Mode state register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg <= MODE_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next mode and per-field edit strobes; a mode edge swallows a coincident increment.
  always_comb begin
    state_next = state_reg;
    inc_hr     = 1'b0;
    inc_min    = 1'b0;
    clear_sec  = 1'b0;
    case (state_reg)
      MODE_RUN: begin
        if (mode_edge) state_next = MODE_SET_HR;
      end
      MODE_SET_HR: begin
        if (mode_edge) state_next = MODE_SET_MIN;
        else if (inc_edge) inc_hr = 1'b1;
      end
      MODE_SET_MIN: begin
        if (mode_edge) begin
          state_next = MODE_RUN;
          clear_sec  = 1'b1;
        end else if (inc_edge) begin
          inc_min = 1'b1;
        end
      end
      default: state_next = MODE_RUN;
    endcase
  end

  // Time-of-day fields: tick-driven carry chain in RUN, single-field edits in SET.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      hours_reg   <= '0;
      minutes_reg <= '0;
      seconds_reg <= '0;
    end else begin
      if (tick) begin
        seconds_reg <= inc_wrap(seconds_reg, SECONDS_MAX);
        if (seconds_reg == SECONDS_MAX) begin
          minutes_reg <= inc_wrap(minutes_reg, MINUTES_MAX);
          if (minutes_reg == MINUTES_MAX) begin
            hours_reg <= 5'(inc_wrap({1'b0, hours_reg}, HOURS_MAX));
          end
        end
      end
      if (inc_hr) begin
        hours_reg <= 5'(inc_wrap({1'b0, hours_reg}, HOURS_MAX));
      end
      if (inc_min) begin
        minutes_reg <= inc_wrap(minutes_reg, MINUTES_MAX);
      end
      if (clear_sec) begin
        seconds_reg <= '0;
      end
    end
  end

  // Seconds strobe, aligned with the cycle the new seconds value appears.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pulse_reg <= 1'b0;
    end else begin
      pulse_reg <= tick;
    end
  end

  // Blink generator: restarts low on every mode change, toggles each quarter second in SET.
  always_ff @(posedge clk_in) begin
    if (rst || (state_next == MODE_RUN) || (state_next != state_reg)) begin
      blink_cnt_reg <= '0;
      blink_reg     <= 1'b0;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_reg <= '0;
      blink_reg     <= ~blink_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
    end
  end

  assign hours     = hours_reg;
  assign minutes   = minutes_reg;
  assign seconds   = seconds_reg;
  assign mode      = state_reg;
  assign sec_pulse = pulse_reg;
  assign blink     = blink_reg;

endmodule
